// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the RV32M multiply/divide sequencer.
// Holds the sequencer state encoding, the funct3 operation encodings and
// the M-extension opcode/funct7 constants that the decoder also uses.
package md_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } md_state_t;

  localparam logic [6:0] OPCODE_M = 7'h33;
  localparam logic [6:0] FUNCT7_M = 7'h01;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

endpackage

// File: rtl/md_sequencer.sv
// md_sequencer: iterative RV32M multiply/divide unit beside the execute stage.
// Captures operands on start, stalls the core for D_WIDTH iterations of
// shift-add multiply or restoring divide, then pulses result_valid for one
// cycle. Divide-by-zero and signed overflow complete in one cycle.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         decoder flag for an M op (held while stalled)
//   funct3        operation select
//   op_a, op_b    rs1 / rs2 values
//   flush         abort current operation
//   stall         freeze PC, suppress register-file write
//   result        writeback value, valid with result_valid
//   result_valid  one-cycle writeback pulse
module md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         funct3,
  input  logic [D_WIDTH-1:0] op_a,
  input  logic [D_WIDTH-1:0] op_b,
  input  logic               flush,
  output logic               stall,
  output logic [D_WIDTH-1:0] result,
  output logic               result_valid
);

  localparam int unsigned CW = $clog2(D_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(D_WIDTH - 1);
  localparam logic [D_WIDTH-1:0] MIN_NEG = {1'b1, {(D_WIDTH-1){1'b0}}};

  md_state_t state, state_nxt;
  logic [CW-1:0] count;
  logic [2:0] f3;
  logic neg_q, neg_r, fixed;
  logic [D_WIDTH-1:0] a_reg, b_reg;
  logic [2*D_WIDTH-1:0] acc;
  logic capture;

  // Operand preparation at capture time
  logic sign_a_en, sign_b_en, sa, sb, div0, ovf, fast;
  logic [D_WIDTH-1:0] abs_a, abs_b, fixed_val;

  always_comb begin
    sign_a_en = !(funct3 == F3_MULHU || funct3 == F3_DIVU || funct3 == F3_REMU);
    sign_b_en = (funct3 == F3_MUL || funct3 == F3_MULH ||
                 funct3 == F3_DIV || funct3 == F3_REM);
    sa = sign_a_en & op_a[D_WIDTH-1];
    sb = sign_b_en & op_b[D_WIDTH-1];
    abs_a = sa ? (-op_a) : op_a;
    abs_b = sb ? (-op_b) : op_b;
    div0 = funct3[2] && (op_b == '0);
    ovf  = (funct3 == F3_DIV || funct3 == F3_REM) && (op_a == MIN_NEG) && (op_b == '1);
    fast = div0 | ovf;
    // funct3[1] separates REM/REMU from DIV/DIVU
    if (div0) fixed_val = funct3[1] ? op_a : '1;
    else      fixed_val = funct3[1] ? '0 : MIN_NEG;
  end

  // FSM next state and stall
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          stall     = 1'b1;
          capture   = 1'b1;
          state_nxt = fast ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (count == LAST) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
    // start is still high while reset is held; keep stall at its reset value
    if (!rst_n) stall = 1'b0;
  end

  // One iteration of multiply (acc shifts right, multiplier in b_reg) or
  // divide (remainder:quotient in acc shifts left, dividend bits from a_reg)
  logic [D_WIDTH:0] mul_sum, div_sh, div_trial;
  logic [D_WIDTH-1:0] div_rem;
  logic div_ge;
  logic [2*D_WIDTH-1:0] mul_acc, div_acc;

  always_comb begin
    mul_sum   = {1'b0, acc[2*D_WIDTH-1:D_WIDTH]} + {1'b0, a_reg};
    mul_acc   = {(b_reg[0] ? mul_sum : {1'b0, acc[2*D_WIDTH-1:D_WIDTH]}), acc[D_WIDTH-1:1]};
    div_sh    = {acc[2*D_WIDTH-1:D_WIDTH], a_reg[D_WIDTH-1]};
    div_trial = div_sh - {1'b0, b_reg};
    div_ge    = !div_trial[D_WIDTH];
    div_rem   = div_ge ? div_trial[D_WIDTH-1:0] : div_sh[D_WIDTH-1:0];
    div_acc   = {div_rem, acc[D_WIDTH-2:0], div_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      f3    <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      fixed <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        f3    <= funct3;
        count <= '0;
        neg_q <= sa ^ sb;
        neg_r <= sa;
        fixed <= fast;
        a_reg <= abs_a;
        b_reg <= abs_b;
        // fast-path value parks in the low accumulator half until DONE
        acc   <= fast ? {{D_WIDTH{1'b0}}, fixed_val} : '0;
      end else if (state == BUSY) begin
        count <= count + 1'b1;
        if (f3[2]) begin
          acc   <= div_acc;
          a_reg <= a_reg << 1;
        end else begin
          acc   <= mul_acc;
          b_reg <= b_reg >> 1;
        end
      end
    end
  end

  // Sign correction and field select from registered state only
  logic [2*D_WIDTH-1:0] prod;
  logic [D_WIDTH-1:0] quo, rem, sel;

  always_comb begin
    prod = neg_q ? (-acc) : acc;
    quo  = neg_q ? (-acc[D_WIDTH-1:0]) : acc[D_WIDTH-1:0];
    rem  = neg_r ? (-acc[2*D_WIDTH-1:D_WIDTH]) : acc[2*D_WIDTH-1:D_WIDTH];
    case (f3)
      F3_MUL:                          sel = prod[D_WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:    sel = prod[2*D_WIDTH-1:D_WIDTH];
      F3_DIV, F3_DIVU:                 sel = quo;
      default:                         sel = rem;
    endcase
    result_valid = (state == DONE) && !flush;
    result       = '0;
    if (result_valid) result = fixed ? acc[D_WIDTH-1:0] : sel;
  end

endmodule
